fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage. Sits directly upstream of the instruction decoder.
//  Holds the PC and issues word reads to a synchronous instruction ROM (1-cycle read latency).
//  Buffers returned words with their PCs and presents them through a valid/ready handshake.
//  Execute can redirect fetch with a taken branch. A redirect flushes the buffer and any read in flight.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  IMEM_AW   10             instruction ROM word-address width
//  DEPTH     2              fetch buffer entries; power of 2, >= 2
// PORTS
//  clk            in   1        single clock; all state changes on posedge
//  rst            in   1        synchronous, active-high reset
//  imem_req       out  1        read strobe to instruction ROM
//  imem_addr      out  IMEM_AW  word address = pc[IMEM_AW+1:2]
//  imem_rdata     in   32       ROM data, valid the cycle after imem_req
//  redirect       in   1        taken branch from execute (one-cycle pulse)
//  redirect_pc    in   32       branch target; bits [1:0] ignored (forced 0)
//  instr          out  32       instruction at head of buffer
//  instr_pc       out  32       PC of instr
//  instr_valid    out  1        head entry valid
//  instr_ready    in   1        decoder accepts head this cycle
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - pc=RESET_PC; buffer empty; rsp_pending=0.
//    - Outputs then read: instr_valid=0, imem_req=0, instr=0, instr_pc=0.
//  - Issue rule: imem_req = ~rst & ~redirect & (count + rsp_pending - pop < DEPTH).
//    - pop = instr_valid & instr_ready.
//    - On issue, pc <= pc + 4. The 32-bit add wraps 0xFFFF_FFFC -> 0.
//  - Response tracking:
//    - rsp_pending <= imem_req. The pending PC is latched alongside it.
//    - Buffer write enable = rsp_pending & ~redirect.
//    - The write captures {imem_rdata, pending_pc}.
//  - Output: instr_valid = (count != 0) & ~redirect. instr and instr_pc come from the head entry.
//    - With an empty buffer, instr and instr_pc hold their last value (0 after reset).
//  - Throughput: 1 instr/cycle sustained while instr_ready=1. No bubbles once primed.
//  - Latency: req issued in cycle N -> data in ROM cycle N+1 -> written at end of N+1 -> instr_valid in N+2.
//  - Redirect (precedence over everything in the same cycle):
//    - Buffer is cleared and the arriving response is discarded.
//    - No request is issued; a handshake in that cycle is void.
//    - pc <= {redirect_pc[31:2], 2'b00}.
//    - First target request goes out in cycle R+1; instr_valid for the target rises in R+3.
//  - Simultaneous push and pop: count unchanged; FIFO order preserved.
//  - Buffer full with instr_ready=0: no issue. pc, contents and outputs are held stable. No overflow possible.
//  - Back-to-back redirects: each redirect overrides the previous one; only the last target is fetched.
//  - rst mid-operation: identical to the reset case above; any in-flight read is dropped.
//  - instr and instr_pc must not change while instr_valid=1 & instr_ready=0.
// STRUCTURE
//  - Shared package cpu_defs: XLEN=32, INSTR_W=32, RESET_PC default, PC_STEP=4.
//  - Sub-module fetch_fifo: synchronous FIFO, width 64 ({pc, instr}), depth DEPTH.
//    - Ports: push, pop, flush, count, head.
//    - flush has priority over push and pop.
//  - The top level holds pc, rsp_pending, pending_pc and the issue/redirect logic only.
// TESTING
//  1. Reset, ROM[i]=0x1000+i, instr_ready=1.
//     -> instr_valid first in cycle 2.
//     -> pcs 0,4,8,12... on consecutive cycles; instr 0x1000, 0x1001...
//  2. instr_ready=0 for 5 cycles mid-stream.
//     -> imem_req drops after the buffer fills (count=DEPTH).
//     -> instr and instr_pc are held; on release the stream resumes with no gap, duplicate or loss.
//  3. redirect=1 with redirect_pc=0x43 while a response is in flight and the buffer holds 2.
//     -> buffer is flushed, the in-flight word is dropped, instr_valid=0 in the redirect cycle.
//     -> next delivered instr_pc=0x40, instr=ROM[16], 3 cycles later.
//  4. Redirects in cycles R and R+1 (targets 0x80, then 0x100).
//     -> no instruction from 0x80 is delivered; first instr_pc=0x100.
//  5. RESET_PC=32'hFFFF_FFF8, instr_ready=1.
//     -> delivered pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap); imem_addr wraps accordingly.
//  6. rst asserted for 1 cycle mid-stream with the buffer non-empty.
//     -> instr_valid=0 next cycle; refetch starts from RESET_PC; no stale word is delivered.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared core widths, reset PC default, PC step and PC alignment helper
package cpu_defs;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: flushable sync FIFO of {pc, instr}; ports push_i/pop_i/flush_i/din_i, count_o, head_o (holds last shown value when empty)
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [W-1:0]             head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] count_q;
  logic [W-1:0] last_q;
  assign count_o = count_q;
  assign head_o = (count_q != '0) ? mem_q[rd_q] : last_q;
  always_ff @(posedge clk)
    if (push_i & ~flush_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      last_q <= '0;
    end else begin
      last_q <= head_o;
      if (flush_i) begin
        rd_q <= '0;
        wr_q <= '0;
        count_q <= '0;
      end else begin
        if (push_i) wr_q <= wr_q + 1'b1;
        if (pop_i) rd_q <= rd_q + 1'b1;
        count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + ROM issue/redirect logic feeding a valid/ready instruction buffer; ports clk/rst, imem_req/addr/rdata, redirect/redirect_pc, instr/instr_pc/instr_valid/instr_ready
module fetch_unit import cpu_defs::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IMEM_AW = 10,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc_q, pc_d, pending_pc_q;
  logic rsp_pending_q, pop;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [XLEN+INSTR_W-1:0] head;
  assign pop = instr_valid & instr_ready;
  // buffered + in-flight entries after this cycle's pop must leave room for one more
  assign occ = (CW+1)'(count) + (CW+1)'(rsp_pending_q) - (CW+1)'(pop);
  assign imem_req = ~rst & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign instr_valid = (count != '0) & ~redirect;
  assign {instr_pc, instr} = head;
  assign pc_d = redirect ? align_pc(redirect_pc) : imem_req ? pc_q + PC_STEP : pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      rsp_pending_q <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      rsp_pending_q <= imem_req;
      if (imem_req) pending_pc_q <= pc_q;
    end
  end
  fetch_fifo #(.W(XLEN + INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(rsp_pending_q & ~redirect),
    .pop_i(pop),
    .flush_i(redirect),
    .din_i({pending_pc_q, imem_rdata}),
    .count_o(count),
    .head_o(head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and directed checks of fetch_unit against a ROM holding 0x1000+index
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, req_a, rdr_a, val_a, rdy_a;
  logic [9:0] addr_a;
  logic [31:0] rdata_a, rpc_a, ins_a, pc_a;
  logic rst_b, req_b, rdr_b, val_b, rdy_b;
  logic [9:0] addr_b;
  logic [31:0] rdata_b, rpc_b, ins_b, pc_b;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(10), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst_a), .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .redirect(rdr_a), .redirect_pc(rpc_a), .instr(ins_a), .instr_pc(pc_a),
    .instr_valid(val_a), .instr_ready(rdy_a));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(10), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .redirect(rdr_b), .redirect_pc(rpc_b), .instr(ins_b), .instr_pc(pc_b),
    .instr_valid(val_b), .instr_ready(rdy_b));

  always_ff @(posedge clk) if (req_a) rdata_a <= 32'h1000 + {22'd0, addr_a};
  always_ff @(posedge clk) if (req_b) rdata_b <= 32'h1000 + {22'd0, addr_b};

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, rdr;
    logic [31:0] rpc;
    logic rdy, req, val;
    logic [31:0] pc, ins;
  } vec_t;
  vec_t v[$];

  initial begin
    rst_a = 1; rdr_a = 0; rpc_a = 0; rdy_a = 1;
    rst_b = 1; rdr_b = 0; rpc_b = 0; rdy_b = 1;
    // rst, rdr, rpc, rdy | req, val, instr_pc, instr
    v.push_back('{1, 0, 0, 1, 0, 0, 32'h00, 32'h0});
    v.push_back('{0, 0, 0, 1, 1, 0, 32'h00, 32'h0});
    v.push_back('{0, 0, 0, 1, 1, 0, 32'h00, 32'h0});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h00, 32'h1000});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h04, 32'h1001});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h08, 32'h1002});
    v.push_back('{0, 0, 0, 0, 0, 1, 32'h0C, 32'h1003});
    v.push_back('{0, 0, 0, 0, 0, 1, 32'h0C, 32'h1003});
    v.push_back('{0, 0, 0, 0, 0, 1, 32'h0C, 32'h1003});
    v.push_back('{0, 0, 0, 0, 0, 1, 32'h0C, 32'h1003});
    v.push_back('{0, 0, 0, 0, 0, 1, 32'h0C, 32'h1003});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h0C, 32'h1003});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h10, 32'h1004});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h14, 32'h1005});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h18, 32'h1006});
    v.push_back('{0, 1, 32'h43, 1, 0, 0, 32'h1C, 32'h1007});
    v.push_back('{0, 0, 0, 1, 1, 0, 32'h1C, 32'h1007});
    v.push_back('{0, 0, 0, 1, 1, 0, 32'h1C, 32'h1007});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h40, 32'h1010});
    v.push_back('{0, 0, 0, 1, 1, 1, 32'h44, 32'h1011});
    repeat (2) @(posedge clk);
    #1;
    foreach (v[i]) begin
      rst_a = v[i].rst; rdr_a = v[i].rdr; rpc_a = v[i].rpc; rdy_a = v[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d req", i), {31'd0, req_a}, {31'd0, v[i].req});
      chk($sformatf("v%0d valid", i), {31'd0, val_a}, {31'd0, v[i].val});
      chk($sformatf("v%0d instr_pc", i), pc_a, v[i].pc);
      chk($sformatf("v%0d instr", i), ins_a, v[i].ins);
      tick();
    end

    // back-to-back redirects: only the second target is fetched
    rdr_a = 1; rpc_a = 32'h80;
    @(negedge clk); chk("rr0 valid", {31'd0, val_a}, 0); chk("rr0 req", {31'd0, req_a}, 0); tick();
    rpc_a = 32'h100;
    @(negedge clk); chk("rr1 valid", {31'd0, val_a}, 0); chk("rr1 req", {31'd0, req_a}, 0); tick();
    rdr_a = 0;
    @(negedge clk); chk("rr2 req", {31'd0, req_a}, 1); chk("rr2 addr", {22'd0, addr_a}, 32'h40); chk("rr2 valid", {31'd0, val_a}, 0); tick();
    @(negedge clk); chk("rr3 valid", {31'd0, val_a}, 0); tick();
    @(negedge clk); chk("rr4 valid", {31'd0, val_a}, 1); chk("rr4 pc", pc_a, 32'h100); chk("rr4 instr", ins_a, 32'h1040); tick();
    @(negedge clk); chk("rr5 valid", {31'd0, val_a}, 1); chk("rr5 pc", pc_a, 32'h104); chk("rr5 instr", ins_a, 32'h1041); tick();

    // reset mid-stream with a non-empty buffer
    rst_a = 1;
    @(negedge clk); chk("mr req", {31'd0, req_a}, 0); tick();
    rst_a = 0;
    @(negedge clk); chk("mr0 valid", {31'd0, val_a}, 0); chk("mr0 pc", pc_a, 0); chk("mr0 instr", ins_a, 0);
    chk("mr0 req", {31'd0, req_a}, 1); chk("mr0 addr", {22'd0, addr_a}, 0); tick();
    @(negedge clk); chk("mr1 valid", {31'd0, val_a}, 0); tick();
    @(negedge clk); chk("mr2 valid", {31'd0, val_a}, 1); chk("mr2 pc", pc_a, 0); chk("mr2 instr", ins_a, 32'h1000); tick();
    @(negedge clk); chk("mr3 pc", pc_a, 32'h4); chk("mr3 instr", ins_a, 32'h1001); tick();

    // PC wrap from 0xFFFF_FFF8 on the DEPTH=4 instance
    rst_b = 0;
    @(negedge clk); chk("wr0 addr", {22'd0, addr_b}, 32'h3FE); chk("wr0 req", {31'd0, req_b}, 1); tick();
    @(negedge clk); chk("wr1 addr", {22'd0, addr_b}, 32'h3FF); tick();
    @(negedge clk); chk("wr2 addr", {22'd0, addr_b}, 32'h000); chk("wr2 pc", pc_b, 32'hFFFF_FFF8); chk("wr2 instr", ins_b, 32'h13FE); tick();
    @(negedge clk); chk("wr3 pc", pc_b, 32'hFFFF_FFFC); chk("wr3 instr", ins_b, 32'h13FF); tick();
    @(negedge clk); chk("wr4 pc", pc_b, 32'h0); chk("wr4 instr", ins_b, 32'h1000); tick();

    // stall so the buffer holds 2 with a read in flight, then redirect to 0x43
    rdy_b = 0;
    @(negedge clk); chk("fl0 pc", pc_b, 32'h4); chk("fl0 req", {31'd0, req_b}, 1); tick();
    rdr_b = 1; rpc_b = 32'h43;
    @(negedge clk); chk("fl1 valid", {31'd0, val_b}, 0); chk("fl1 req", {31'd0, req_b}, 0); tick();
    rdr_b = 0; rdy_b = 1;
    @(negedge clk); chk("fl2 addr", {22'd0, addr_b}, 32'h10); chk("fl2 valid", {31'd0, val_b}, 0); tick();
    @(negedge clk); chk("fl3 valid", {31'd0, val_b}, 0); tick();
    @(negedge clk); chk("fl4 valid", {31'd0, val_b}, 1); chk("fl4 pc", pc_b, 32'h40); chk("fl4 instr", ins_b, 32'h1010); tick();
    @(negedge clk); chk("fl5 pc", pc_b, 32'h44); chk("fl5 instr", ins_b, 32'h1011); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
